pe_lx: RTL

PE_LX -- requirements
Module: pe_lx

---
 rtl/pe_lx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pe_lx.sv
// pe_lx: LANES-wide fixed-point PE; single-beat gemm MAC plus multi-beat unary Horner evaluation.
// Optional macro PE_LX_SAT_EN: saturate accumulator sums and raise sticky per-lane sat_o flags.
module pe_lx #(
  parameter int LANES    = 4,
  parameter int INT_BW   = 5,
  parameter int FRA_BW   = 10,
  parameter int MUL_BW   = 16,
  parameter int ACC_BW   = 32,
  parameter int UNO_ITER = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode_i,
  input  logic                      start_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*MUL_BW-1:0]   x_i,
  input  logic [LANES*MUL_BW-1:0]   wc_i,
  input  logic [LANES*ACC_BW-1:0]   o_i,
  output logic [LANES*MUL_BW-1:0]   x_o,
  output logic [LANES*MUL_BW-1:0]   wc_o,
  output logic [LANES*ACC_BW-1:0]   o_o,
  output logic                      o_valid_o,
  output logic [1:0]                mode_o,
  output logic                      busy_o,
  output logic [LANES-1:0]          sat_o
);

  localparam int PROD_W = 2 * MUL_BW;
  localparam int SUM_W  = ((PROD_W > ACC_BW) ? PROD_W : ACC_BW) + 1;
  localparam int CNT_W  = $clog2(UNO_ITER + 1);

  localparam logic signed [ACC_BW-1:0] MUL_MAX = {{(ACC_BW-MUL_BW+1){1'b0}}, {(MUL_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] MUL_MIN = {{(ACC_BW-MUL_BW+1){1'b1}}, {(MUL_BW-1){1'b0}}};
`ifdef PE_LX_SAT_EN
  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_BW+1){1'b0}}, {(ACC_BW-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_BW+1){1'b1}}, {(ACC_BW-1){1'b0}}};
`endif

  if (INT_BW + FRA_BW + 1 != MUL_BW || UNO_ITER < 2) begin : g_bad_cfg
    $error("pe_lx: MUL_BW must equal 1+INT_BW+FRA_BW and UNO_ITER must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_inc;
  logic signed [ACC_BW-1:0]  r_acc  [LANES];
  logic signed [MUL_BW-1:0]  r_xreg [LANES];
  logic [LANES*ACC_BW-1:0]   r_o;
  logic [LANES*MUL_BW-1:0]   r_x_o, r_wc_o;
  logic                      r_o_valid;
  logic [1:0]                r_mode;
  logic                      w_gemm_fire, w_start, w_run_fire, w_run_last;
  logic signed [ACC_BW-1:0]  w_gemm_sum [LANES];
  logic signed [ACC_BW-1:0]  w_horn_sum [LANES];
  logic signed [ACC_BW-1:0]  w_acc_init [LANES];

  // Fixed-point narrowing of the accumulator back to a multiplier operand.
  function automatic logic signed [MUL_BW-1:0] trunc_acc(input logic signed [ACC_BW-1:0] a);
    logic signed [ACC_BW-1:0] sh;
    sh = a >>> FRA_BW;
    if (sh > MUL_MAX) return MUL_MAX[MUL_BW-1:0];
    if (sh < MUL_MIN) return MUL_MIN[MUL_BW-1:0];
    return sh[MUL_BW-1:0];
  endfunction

  function automatic logic signed [ACC_BW-1:0] acc_add(input logic signed [PROD_W-1:0] prod,
                                                       input logic signed [SUM_W-1:0]  addend);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(prod) + addend;
`ifdef PE_LX_SAT_EN
    if (s > ACC_MAX) return ACC_MAX[ACC_BW-1:0];
    if (s < ACC_MIN) return ACC_MIN[ACC_BW-1:0];
`endif
    return s[ACC_BW-1:0];
  endfunction

`ifdef PE_LX_SAT_EN
  logic [LANES-1:0] r_sat, w_gemm_ovf, w_horn_ovf;

  function automatic logic acc_ovf(input logic signed [PROD_W-1:0] prod,
                                   input logic signed [SUM_W-1:0]  addend);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(prod) + addend;
    return (s > ACC_MAX) || (s < ACC_MIN);
  endfunction
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [MUL_BW-1:0] w_x, w_wc;
    logic signed [SUM_W-1:0]  w_oi_ext, w_wc_sh;
    logic signed [PROD_W-1:0] w_gemm_prod, w_horn_prod;

    assign w_x         = $signed(x_i[k*MUL_BW +: MUL_BW]);
    assign w_wc        = $signed(wc_i[k*MUL_BW +: MUL_BW]);
    assign w_oi_ext    = SUM_W'($signed(o_i[k*ACC_BW +: ACC_BW]));
    assign w_wc_sh     = SUM_W'(w_wc) <<< FRA_BW;
    // Products are formed at full 2*MUL_BW width before joining the accumulator add.
    assign w_gemm_prod = PROD_W'(w_wc) * PROD_W'(w_x);
    assign w_horn_prod = PROD_W'(trunc_acc(r_acc[k])) * PROD_W'(r_xreg[k]);
    assign w_gemm_sum[k] = acc_add(w_gemm_prod, w_oi_ext);
    assign w_horn_sum[k] = acc_add(w_horn_prod, w_wc_sh);
    assign w_acc_init[k] = ACC_BW'(w_wc) <<< FRA_BW;
`ifdef PE_LX_SAT_EN
    assign w_gemm_ovf[k] = acc_ovf(w_gemm_prod, w_oi_ext);
    assign w_horn_ovf[k] = acc_ovf(w_horn_prod, w_wc_sh);
`endif
  end

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    busy_o      = 1'b0;
    w_gemm_fire = 1'b0;
    w_start     = 1'b0;
    w_run_fire  = 1'b0;
    w_run_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mode_i == 2'b00) begin
          in_ready_o  = 1'b1;
          w_gemm_fire = in_valid_i;
        end else if (start_i) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
        w_run_fire = in_valid_i;
        w_run_last = in_valid_i && (w_cnt_inc == CNT_W'(UNO_ITER));
        if (w_run_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: r_acc/r_xreg are per-lane flops, not a RAM, so clearing them in reset is legal and cheap.
      r_cnt     <= '0;
      r_o_valid <= 1'b0;
      r_mode    <= 2'b00;
      r_o       <= '0;
      r_x_o     <= '0;
      r_wc_o    <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_acc[k]  <= '0;
        r_xreg[k] <= '0;
      end
    end else begin
      r_o_valid <= 1'b0;
      if (w_gemm_fire) begin
        r_o_valid <= 1'b1;
        r_mode    <= 2'b00;
        r_x_o     <= x_i;
        r_wc_o    <= wc_i;
        for (int k = 0; k < LANES; k++) r_o[k*ACC_BW +: ACC_BW] <= w_gemm_sum[k];
      end
      if (w_start) begin
        r_mode <= mode_i;
        r_cnt  <= CNT_W'(1);
        for (int k = 0; k < LANES; k++) begin
          r_acc[k]  <= w_acc_init[k];
          r_xreg[k] <= $signed(x_i[k*MUL_BW +: MUL_BW]);
        end
      end
      if (w_run_fire) begin
        r_cnt <= w_cnt_inc;
        for (int k = 0; k < LANES; k++) r_acc[k] <= w_horn_sum[k];
        if (w_run_last) begin
          r_o_valid <= 1'b1;
          for (int k = 0; k < LANES; k++) r_o[k*ACC_BW +: ACC_BW] <= w_horn_sum[k];
        end
      end
    end
  end

`ifdef PE_LX_SAT_EN
  always_ff @(posedge clk) begin
    if (rst)              r_sat <= '0;
    else if (w_gemm_fire) r_sat <= r_sat | w_gemm_ovf;
    else if (w_run_fire)  r_sat <= r_sat | w_horn_ovf;
  end
  assign sat_o = r_sat;
`else
  assign sat_o = '0;
`endif

  assign x_o       = r_x_o;
  assign wc_o      = r_wc_o;
  assign o_o       = r_o;
  assign o_valid_o = r_o_valid;
  assign mode_o    = r_mode;

endmodule
